axis_loopback_fifo: RTL and testbench
=====================================

// Module: axis_loopback_fifo
// PURPOSE
// - AXI4-Stream loopback buffer between the DMA MM2S stream output and the S2MM stream input.
// - Accepts beats from m_axis_mm2s_* (acts as sink) and replays them in order on s_axis_s2mm_* (acts as source).
// - Closes the MM2S->S2MM path so one DMA program can move memory->stream->memory.
// - First-word-fall-through FIFO; tdata/tkeep/tlast preserved bit-exact; reports occupancy and packet count.
// PARAMETERS
// - DATA_WIDTH  32  tdata width; default taken from params_pkg::DATA_WIDTH; multiple of 8.
// - KEEP_WIDTH  DATA_WIDTH/8  tkeep width; 4 at default.
// - DEPTH       16  FIFO entries; power of 2, >= 2.
// - CNT_WIDTH   16  width of pkt_count.
// PORTS
// - axi_aclk             in   1                 clock; all logic on rising edge.
// - axi_resetn           in   1                 asynchronous active-low reset.
// - m_axis_mm2s_tdata    in   DATA_WIDTH        beat data from DMA MM2S.
// - m_axis_mm2s_tkeep    in   KEEP_WIDTH        byte enables from DMA MM2S.
// - m_axis_mm2s_tvalid   in   1                 MM2S beat valid.
// - m_axis_mm2s_tready   out  1                 this block can accept a beat.
// - m_axis_mm2s_tlast    in   1                 last beat of packet.
// - s_axis_s2mm_tdata    out  DATA_WIDTH        beat data to DMA S2MM.
// - s_axis_s2mm_tkeep    out  KEEP_WIDTH        byte enables to DMA S2MM.
// - s_axis_s2mm_tvalid   out  1                 head entry is valid.
// - s_axis_s2mm_tready   in   1                 DMA S2MM accepts the beat.
// - s_axis_s2mm_tlast    out  1                 head beat is last of packet.
// - occupancy            out  $clog2(DEPTH)+1   entries currently stored (0..DEPTH).
// - pkt_count            out  CNT_WIDTH         packets fully emitted (tlast handshakes on output).
// BEHAVIOUR
// Reset (axi_resetn low, async):
// - Pointers, occupancy and pkt_count clear to 0; s_axis_s2mm_tvalid = 0; m_axis_mm2s_tready = 0.
// - Reset during a packet drops all stored beats. No partial state survives.
// - m_axis_mm2s_tready rises on the first clock edge after reset deassertion.
// Storage:
// - Entry = {tlast, tkeep, tdata}, stored in a DEPTH-entry array.
// - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; MSB used for wrap detection.
// - full  when pointer LSBs are equal and MSBs differ.
// - empty when the pointers are equal.
// Input handshake:
// - push = m_axis_mm2s_tvalid & m_axis_mm2s_tready.
// - m_axis_mm2s_tready = registered !full. It is computed from next-state occupancy, so when full it goes low the same cycle the last slot fills.
// Output handshake:
// - pop = s_axis_s2mm_tvalid & s_axis_s2mm_tready.
// - s_axis_s2mm_tvalid = !empty. Data/keep/last are driven from the head entry.
// - Once tvalid is high, the outputs hold stable until pop (AXIS rule).
// Latency:
// - A beat pushed at edge N is visible on s_axis_s2mm_* after edge N (1-cycle fall-through when empty).
// Simultaneous push and pop:
// - Both occur; occupancy is unchanged.
// - When full, tready is low, so no push. A pop that cycle frees a slot; tready returns high the next cycle.
// - When empty, push and pop cannot coincide: tvalid is low, so the new beat appears next cycle.
// Wrap-around:
// - Pointers increment modulo 2*DEPTH; storage index = pointer LSBs.
// - Ordering and the tlast position are preserved across the wrap.
// Counters:
// - occupancy = wr_ptr - rd_ptr, width $clog2(DEPTH)+1; never exceeds DEPTH.
// - pkt_count increments by 1 on each pop with tlast=1; wraps 2^CNT_WIDTH-1 -> 0; no saturation.
// Other:
// - No packet reshaping. tkeep is passed through even if sparse. A zero-length packet is impossible (a tlast beat always carries data).
// - X on tdata while tvalid=0 is tolerated and never stored.
// TESTING
// 1. Reset: hold axi_resetn low 5 clks -> tvalid=0, occupancy=0, pkt_count=0, tready=0; 1 clk after release tready=1.
// 2. Single packet: push 4 beats 0x11111111..0x44444444, tkeep=0xF, tlast on beat 4, sink always ready -> same 4 beats out in order, each 1 clk after push; pkt_count=1.
// 3. Backpressure/full: sink tready=0, push 20 beats -> exactly 16 accepted; tready=0 with occupancy=16.
//    Release sink -> 16 beats out in order; tready=1 one clk after first pop.
// 4. Wrap + simultaneous: 3 packets of 7 beats, tkeep=0x3 on each last beat, random sink tready (50%) -> output matches input across pointer wrap; tkeep=0x3 exact; pkt_count=3.
// 5. Mid-packet reset: push 5 beats of an 8-beat packet, assert reset -> occupancy=0, tvalid=0, nothing emitted afterward; new packet after reset passes cleanly.
// 6. Counter wrap (CNT_WIDTH=4): send 17 single-beat tlast packets -> pkt_count reads 1.

Source files
------------

// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared stream parameters for the DMA loopback path
package params_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/axis_loopback_fifo.sv
// rtl/axis_loopback_fifo.sv - first-word-fall-through AXIS FIFO closing DMA MM2S back into S2MM
module axis_loopback_fifo #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic [DATA_WIDTH-1:0]      m_axis_mm2s_tdata,
  input  logic [KEEP_WIDTH-1:0]      m_axis_mm2s_tkeep,
  input  logic                       m_axis_mm2s_tvalid,
  output logic                       m_axis_mm2s_tready,
  input  logic                       m_axis_mm2s_tlast,
  output logic [DATA_WIDTH-1:0]      s_axis_s2mm_tdata,
  output logic [KEEP_WIDTH-1:0]      s_axis_s2mm_tkeep,
  output logic                       s_axis_s2mm_tvalid,
  input  logic                       s_axis_s2mm_tready,
  output logic                       s_axis_s2mm_tlast,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_WIDTH-1:0]       pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full_nxt;
  logic          tready_q;

  assign empty = (wr_ptr == rd_ptr);
  assign push  = m_axis_mm2s_tvalid & tready_q;
  assign pop   = s_axis_s2mm_tvalid & s_axis_s2mm_tready;

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
  // Ready is registered, so it must already reflect the slot a push this cycle consumes.
  assign full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                      (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tready_q  <= 1'b0;
      pkt_count <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      tready_q <= !full_nxt;
      if (pop && s_axis_s2mm_tlast) begin
        pkt_count <= pkt_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {m_axis_mm2s_tlast, m_axis_mm2s_tkeep, m_axis_mm2s_tdata};
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];

  assign m_axis_mm2s_tready = tready_q;
  assign s_axis_s2mm_tvalid = !empty;
  assign s_axis_s2mm_tdata  = head[DATA_WIDTH-1:0];
  assign s_axis_s2mm_tkeep  = head[DATA_WIDTH +: KEEP_WIDTH];
  assign s_axis_s2mm_tlast  = head[EW-1];
  assign occupancy          = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// tb/tb_axis_loopback_fifo.sv - directed and table-driven checks for axis_loopback_fifo
module tb_axis_loopback_fifo;

  logic        axi_aclk = 1'b0;
  logic        axi_resetn;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [4:0]  occupancy;
  logic [3:0]  pkt_count;

  int checks = 0;
  int errors = 0;

  always #5 axi_aclk = ~axi_aclk;

  axis_loopback_fifo #(
    .DATA_WIDTH(32), .KEEP_WIDTH(4), .DEPTH(16), .CNT_WIDTH(4)
  ) dut (
    .axi_aclk(axi_aclk),
    .axi_resetn(axi_resetn),
    .m_axis_mm2s_tdata(m_tdata),
    .m_axis_mm2s_tkeep(m_tkeep),
    .m_axis_mm2s_tvalid(m_tvalid),
    .m_axis_mm2s_tready(m_tready),
    .m_axis_mm2s_tlast(m_tlast),
    .s_axis_s2mm_tdata(s_tdata),
    .s_axis_s2mm_tkeep(s_tkeep),
    .s_axis_s2mm_tvalid(s_tvalid),
    .s_axis_s2mm_tready(s_tready),
    .s_axis_s2mm_tlast(s_tlast),
    .occupancy(occupancy),
    .pkt_count(pkt_count)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        sr;
    logic        e_tr;
    logic        e_tv;
    logic [31:0] e_d;
    logic        e_l;
    logic [4:0]  e_occ;
    logic [3:0]  e_pkt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  // Drives n beats through the FIFO and checks every output beat against an in-order queue.
  task automatic stream(input int n, input int plen, input logic [3:0] lkeep,
                        input bit rnd, input logic [31:0] base);
    logic [36:0] exp_q[$];
    logic [36:0] e;
    int sent = 0;
    int cyc  = 0;
    bit done = 0;
    while (!done && cyc < 2000) begin
      step();
      cyc++;
      if (sent < n) begin
        m_tvalid = 1'b1;
        m_tdata  = base + 32'(sent) * 32'h0101_0101;
        m_tlast  = ((sent % plen) == plen - 1);
        m_tkeep  = m_tlast ? lkeep : 4'hF;
      end else begin
        m_tvalid = 1'b0;
        m_tdata  = 'x;
      end
      s_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge axi_aclk);
      if (s_tvalid && s_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {s_tlast, s_tkeep, s_tdata}, 37'h0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_beat", {s_tlast, s_tkeep, s_tdata}, e);
        end
      end
      if (m_tvalid && m_tready) begin
        exp_q.push_back({m_tlast, m_tkeep, m_tdata});
        sent++;
      end
      done = (sent == n) && (exp_q.size() == 0);
    end
    if (!done) chk("stream_timeout", 64'(cyc), 64'(0));
    step();
    m_tvalid = 1'b0;
    s_tready = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    axi_resetn = 1'b0;
    repeat (5) @(posedge axi_aclk);
    #1;
    axi_resetn = 1'b1;
  endtask

  vec_t vecs[5];
  int   acc;

  initial begin
    axi_resetn = 1'b0;
    m_tvalid = 1'b0; m_tdata = '0; m_tkeep = '0; m_tlast = 1'b0; s_tready = 1'b0;

    // Reset state
    repeat (5) @(posedge axi_aclk);
    #1;
    chk("rst_tvalid", s_tvalid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_tready", m_tready, 0);
    axi_resetn = 1'b1;
    #1;
    chk("rel_tready_before_edge", m_tready, 0);
    step();
    chk("rel_tready_after_edge", m_tready, 1);

    // Single packet, sink always ready: table of per-cycle inputs and outputs after the edge
    vecs[0] = '{1, 32'h1111_1111, 4'hF, 0, 1, 1, 1, 32'h1111_1111, 0, 5'd1, 4'd0};
    vecs[1] = '{1, 32'h2222_2222, 4'hF, 0, 1, 1, 1, 32'h2222_2222, 0, 5'd1, 4'd0};
    vecs[2] = '{1, 32'h3333_3333, 4'hF, 0, 1, 1, 1, 32'h3333_3333, 0, 5'd1, 4'd0};
    vecs[3] = '{1, 32'h4444_4444, 4'hF, 1, 1, 1, 1, 32'h4444_4444, 1, 5'd1, 4'd0};
    vecs[4] = '{0, 32'h0,         4'h0, 0, 1, 1, 0, 32'h0,         0, 5'd0, 4'd1};
    for (int i = 0; i < 5; i++) begin
      m_tvalid = vecs[i].v; m_tdata = vecs[i].d; m_tkeep = vecs[i].k;
      m_tlast = vecs[i].l; s_tready = vecs[i].sr;
      step();
      chk($sformatf("v%0d_tready", i), m_tready, vecs[i].e_tr);
      chk($sformatf("v%0d_tvalid", i), s_tvalid, vecs[i].e_tv);
      if (vecs[i].e_tv) begin
        chk($sformatf("v%0d_tdata", i), s_tdata, vecs[i].e_d);
        chk($sformatf("v%0d_tlast", i), s_tlast, vecs[i].e_l);
        chk($sformatf("v%0d_tkeep", i), s_tkeep, 4'hF);
      end
      chk($sformatf("v%0d_occ", i), occupancy, vecs[i].e_occ);
      chk($sformatf("v%0d_pkt", i), pkt_count, vecs[i].e_pkt);
    end

    // Backpressure until full
    s_tready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      m_tvalid = 1'b1;
      m_tdata  = 32'hA000_0000 + 32'(acc);
      m_tkeep  = 4'hF;
      m_tlast  = 1'b0;
      @(negedge axi_aclk);
      if (m_tready) acc++;
      step();
    end
    m_tvalid = 1'b0;
    chk("full_accepted", 64'(acc), 64'(16));
    chk("full_tready", m_tready, 0);
    chk("full_occ", occupancy, 16);
    s_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_tvalid", s_tvalid, 1);
      chk($sformatf("drain_data%0d", i), s_tdata, 32'hA000_0000 + 32'(i));
      step();
      if (i == 0) begin
        chk("tready_after_first_pop", m_tready, 1);
        chk("occ_after_first_pop", occupancy, 15);
      end
    end
    chk("drain_empty_tvalid", s_tvalid, 0);
    chk("drain_occ", occupancy, 0);
    chk("drain_pkt", pkt_count, 1);

    // Three 7-beat packets across the pointer wrap with random sink readiness
    stream(21, 7, 4'h3, 1, 32'h5000_0000);
    chk("wrap_pkt", pkt_count, 4);
    chk("wrap_occ", occupancy, 0);

    // Mid-packet reset
    s_tready = 1'b0;
    stream_partial: begin
      int pushed = 0;
      for (int c = 0; c < 20 && pushed < 5; c++) begin
        m_tvalid = 1'b1;
        m_tdata  = 32'hC000_0000 + 32'(pushed);
        m_tkeep  = 4'hF;
        m_tlast  = 1'b0;
        @(negedge axi_aclk);
        if (m_tready) pushed++;
        step();
      end
      m_tvalid = 1'b0;
    end
    chk("mid_occ_before_rst", occupancy, 5);
    axi_resetn = 1'b0;
    #1;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_tvalid", s_tvalid, 0);
    chk("mid_rst_tready", m_tready, 0);
    chk("mid_rst_pkt", pkt_count, 0);
    repeat (2) @(posedge axi_aclk);
    #1;
    axi_resetn = 1'b1;
    s_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_output", s_tvalid, 0);
    end
    stream(3, 3, 4'hF, 0, 32'hD000_0000);
    chk("post_rst_pkt", pkt_count, 1);

    // Packet counter wrap at CNT_WIDTH=4
    do_reset();
    step();
    stream(17, 1, 4'hF, 0, 32'hE000_0000);
    chk("cnt_wrap_pkt", pkt_count, 1);
    chk("cnt_wrap_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
